fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch sequencer for the Chronos pipelined RV32I core. It owns the PC and drives the single-outstanding request/valid handshake to instruction memory. It presents fetched instructions to decode with back-pressure, and applies branch redirects from the predictor/execute stage. Stale responses are squashed, and the NOP-select for the IF/ID mux is generated here.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] ignored (forced 0)
- `NOP_INST`, 32'h0000_0013, instruction word presented when `inst_valid`=0 (addi x0,x0,0)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset (sampled on `clk` rising edge)
- `en`  in  1  fetch enable; low stops new requests after any outstanding one completes
- `fetch_req`  out  1  one-cycle request strobe to instruction memory
- `fetch_addr`  out  32  request address, valid while `fetch_req`=1
- `fetch_data_valid`  in  1  memory response strobe, ≥1 cycle after request
- `request_data`  in  32  response word, valid with `fetch_data_valid`
- `redirect_valid`  in  1  branch/mispredict redirect strobe
- `redirect_pc`  in  32  redirect target
- `stall`  in  1  decode cannot accept this cycle
- `inst_valid`  out  1  `inst`/`inst_pc` hold a real instruction
- `inst`  out  32  instruction to decode; `NOP_INST` when `inst_valid`=0
- `inst_pc`  out  32  PC of `inst`
- `pc_sel`  out  1  IF/ID mux select; equals `~inst_valid` (1 = inject NOP)
- `kill`  out  1  one-cycle pulse the cycle after a redirect is accepted; flushes decode

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE → REQ when `en`. REQ: `fetch_req`=1, `fetch_addr`=pc → WAIT.
- WAIT, on `fetch_data_valid`: `inst`←`request_data`, `inst_pc`←pc, `inst_valid`←1, pc←pc+4 (mod 2^32) → HOLD.
- HOLD, on `!stall` (consume): `inst_valid`←0; → REQ if `en`, else IDLE. With `stall`=1, outputs are held unchanged.
- Redirect (`redirect_valid`=1) has priority in every state:
  - pc←{`redirect_pc`[31:2],2'b00}
  - `inst_valid`←0
  - `kill`←1 next cycle
- Next state after a redirect:
  - IDLE/HOLD → REQ (IDLE if `!en`).
  - REQ or WAIT without same-cycle response → DRAIN.
  - WAIT with same-cycle `fetch_data_valid` → response discarded → REQ.
  - DRAIN → stays DRAIN; target is updated to the newest `redirect_pc`.
- DRAIN, on `fetch_data_valid`: response discarded → REQ (IDLE if `!en`). No second request is ever issued while one is outstanding.
- `fetch_data_valid` in IDLE, REQ or HOLD is a protocol error and is ignored.
- `en` low mid-request: the outstanding request completes normally; the instruction is delivered; then the block parks in IDLE.

## Timing
- Reset values:
  - state=IDLE, pc=`RESET_PC`
  - `fetch_req`=0, `fetch_addr`=`RESET_PC`
  - `inst_valid`=0, `inst`=`NOP_INST`, `inst_pc`=`RESET_PC`
  - `pc_sel`=1, `kill`=0
- `rst` mid-request: takes effect at that edge; the outstanding response is dropped (memory is reset on the same `rst`).
- All outputs registered except `pc_sel` (pure inverter of the `inst_valid` flop).
- First `fetch_req` is on the 2nd cycle after `rst` falls with `en`=1 (IDLE→REQ).
- With 1-cycle memory and no stall: one instruction per 3 cycles (REQ, WAIT, HOLD). `inst_valid` rises the cycle after `fetch_data_valid`.
- Redirect → `fetch_req` at the new target:
  - 2 cycles from HOLD/IDLE.
  - From DRAIN, 1 cycle after the stale response.

## Configuration
- `FETCH_CTRL_PERF_EN` defined: adds two outputs, each reset to 0 and wrapping at 2^32.
  - `perf_fetch_cnt` (32): increments per consumed instruction.
  - `perf_squash_cnt` (32): increments per discarded response plus per valid instruction dropped by a redirect.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, `en`=1, 1-cycle memory returning addr^32'hA5A5_0000: `fetch_addr` sequence 0,4,8 at 3-cycle spacing; `inst_pc` matches; `pc_sel`=0 only while `inst_valid`.
- `stall` held 5 cycles in HOLD: `inst`/`inst_pc` stable, `fetch_req`=0 throughout; next request 1 cycle after `stall` falls.
- `redirect_valid` with `redirect_pc`=32'h0000_0103 in WAIT, memory latency 4: stale response discarded, `kill` pulses once, next `fetch_addr`=32'h0000_0100, `inst_valid` stays 0 until the new response arrives.
- Redirect and `fetch_data_valid` in the same cycle: returned word never appears on `inst`; next `fetch_addr`=`redirect_pc`.
- Two redirects in DRAIN (0x200 then 0x300): after the stale response, `fetch_addr`=0x300.
- `rst` asserted in WAIT, then `en` low: state IDLE, no `fetch_req`, all outputs at reset values; with `FETCH_CTRL_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between fetch_ctrl, instruction memory, the redirect source and decode.
interface fetch_ctrl_if;
    // fetch_req is a one-cycle strobe and the memory answers exactly once with
    // fetch_data_valid; decode takes inst when inst_valid=1 and stall=0 on the same edge.
    logic        en;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_data_valid;
    logic [31:0] request_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        pc_sel;
    logic        kill;

    modport master (
        input  en, fetch_data_valid, request_data, redirect_valid, redirect_pc, stall,
        output fetch_req, fetch_addr, inst_valid, inst, inst_pc, pc_sel, kill
    );

    modport slave (
        output en, fetch_data_valid, request_data, redirect_valid, redirect_pc, stall,
        input  fetch_req, fetch_addr, inst_valid, inst, inst_pc, pc_sel, kill
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding fetch sequencer: owns the PC, squashes stale responses, feeds decode.
// Optional FETCH_CTRL_PERF_EN adds fetch/squash event counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_ctrl_if.master bus,
    output logic [2:0]   state_o
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]  perf_fetch_cnt_o,
    output logic [31:0]  perf_squash_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_req_q, fetch_req_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        kill_q, kill_d;
    logic        consume;
    logic        squash_resp;
    logic        drop_valid;
    logic        fetch_en;
    logic [31:0] redirect_target;

    assign fetch_en        = bus.en;
    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        consume      = 1'b0;
        squash_resp  = 1'b0;
        drop_valid   = 1'b0;

        if (bus.redirect_valid) begin
            pc_d         = redirect_target;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            drop_valid   = inst_valid_q;
            case (state_q)
                ST_IDLE, ST_HOLD: state_d = fetch_en ? ST_REQ : ST_IDLE;
                ST_REQ:           state_d = ST_DRAIN;
                ST_WAIT, ST_DRAIN: begin
                    // A response landing with the redirect is the stale one; nothing is left in flight.
                    if (bus.fetch_data_valid) begin
                        squash_resp = 1'b1;
                        state_d     = fetch_en ? ST_REQ : ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default:          state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: if (fetch_en) state_d = ST_REQ;
                ST_REQ:  state_d = ST_WAIT;
                ST_WAIT: begin
                    if (bus.fetch_data_valid) begin
                        inst_d       = bus.request_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                        state_d      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!bus.stall) begin
                        consume      = 1'b1;
                        inst_valid_d = 1'b0;
                        inst_d       = NOP_INST;
                        state_d      = fetch_en ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.fetch_data_valid) begin
                        squash_resp = 1'b1;
                        state_d     = fetch_en ? ST_REQ : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        fetch_req_d  = (state_d == ST_REQ);
        fetch_addr_d = fetch_req_d ? pc_d : fetch_addr_q;
        kill_d       = bus.redirect_valid;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC_ALIGNED;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= RESET_PC_ALIGNED;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= RESET_PC_ALIGNED;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_req_q  <= fetch_req_d;
            fetch_addr_q <= fetch_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            kill_q       <= kill_d;
        end
    end

    assign bus.fetch_req  = fetch_req_q;
    assign bus.fetch_addr = fetch_addr_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.pc_sel     = ~inst_valid_q;
    assign bus.kill       = kill_q;
    assign state_o        = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt_q;
    logic [31:0] perf_squash_cnt_q;

    // At most one squash event per cycle: a valid instruction only exists in HOLD, where no response is legal.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_cnt_q  <= 32'd0;
            perf_squash_cnt_q <= 32'd0;
        end else begin
            perf_fetch_cnt_q  <= perf_fetch_cnt_q + {31'd0, consume};
            perf_squash_cnt_q <= perf_squash_cnt_q + {31'd0, squash_resp | drop_valid};
        end
    end

    assign perf_fetch_cnt_o  = perf_fetch_cnt_q;
    assign perf_squash_cnt_o = perf_squash_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = ^{consume, squash_resp, drop_valid};
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: memory model with programmable latency plus an in-order scoreboard.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;
    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_DRAIN = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] state;
    int tests_run = 0;
    int tests_failed = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_ctrl_if bus();

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_squash;
    fetch_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus), .state_o(state),
                    .perf_fetch_cnt_o(perf_fetch), .perf_squash_cnt_o(perf_squash));
`else
    fetch_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus), .state_o(state));
`endif

    // Memory model: answers mem_lat cycles after the request cycle with addr ^ KEY.
    int          mem_lat = 1;
    int          mem_cnt = 0;
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'd0;

    always @(negedge clk) begin
        bus.fetch_data_valid = 1'b0;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.fetch_data_valid = 1'b1;
                    bus.request_data     = mem_addr ^ KEY;
                    mem_pend             = 1'b0;
                end
            end
            if (bus.fetch_req) begin
                tests_run++;
                if (mem_pend) begin
                    tests_failed++;
                    $display("FAIL second_outstanding: req addr %h while %h pending", bus.fetch_addr, mem_addr);
                end
                mem_pend = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = bus.fetch_addr;
            end
        end
    end

    // Scoreboard: every new instruction on decode must match the head of exp_q.
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            tests_run++;
            if (bus.pc_sel !== ~bus.inst_valid) begin
                tests_failed++;
                $display("FAIL pc_sel: got %b, inst_valid %b", bus.pc_sel, bus.inst_valid);
            end
            if (!bus.inst_valid) begin
                tests_run++;
                if (bus.inst !== NOP) begin
                    tests_failed++;
                    $display("FAIL nop_when_invalid: got %h want %h", bus.inst, NOP);
                end
            end
            if (bus.inst_valid && !prev_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_inst: pc %h inst %h with empty queue", bus.inst_pc, bus.inst);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({bus.inst_pc, bus.inst} !== e) begin
                        tests_failed++;
                        $display("FAIL scoreboard: got pc %h inst %h want pc %h inst %h",
                                 bus.inst_pc, bus.inst, e[63:32], e[31:0]);
                    end
                end
            end
            prev_valid = bus.inst_valid;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, pc ^ KEY});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(input int bound, output int n);
        n = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            n++;
            if (bus.fetch_req) return;
        end
        tests_run++;
        tests_failed++;
        $display("FAIL wait_req_timeout: no fetch_req within %0d cycles", bound);
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (bus.inst_valid) return;
        end
        tests_run++;
        tests_failed++;
        $display("FAIL wait_valid_timeout: no inst_valid within %0d cycles", bound);
    endtask

    task automatic check_queue_empty(input string name);
        step();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_queue: %0d expected instructions never delivered", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        tests_run += 8;
        if (state !== S_IDLE)         begin tests_failed++; $display("FAIL rst_state: got %0d want %0d", state, S_IDLE); end
        if (bus.fetch_req !== 1'b0)   begin tests_failed++; $display("FAIL rst_fetch_req: got %b want 0", bus.fetch_req); end
        if (bus.fetch_addr !== 32'd0) begin tests_failed++; $display("FAIL rst_fetch_addr: got %h want 0", bus.fetch_addr); end
        if (bus.inst_valid !== 1'b0)  begin tests_failed++; $display("FAIL rst_inst_valid: got %b want 0", bus.inst_valid); end
        if (bus.inst !== NOP)         begin tests_failed++; $display("FAIL rst_inst: got %h want %h", bus.inst, NOP); end
        if (bus.inst_pc !== 32'd0)    begin tests_failed++; $display("FAIL rst_inst_pc: got %h want 0", bus.inst_pc); end
        if (bus.pc_sel !== 1'b1)      begin tests_failed++; $display("FAIL rst_pc_sel: got %b want 1", bus.pc_sel); end
        if (bus.kill !== 1'b0)        begin tests_failed++; $display("FAIL rst_kill: got %b want 0", bus.kill); end
`ifdef FETCH_CTRL_PERF_EN
        tests_run++;
        if (perf_fetch !== 32'd0 || perf_squash !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_fetch, perf_squash);
        end
`endif
    endtask

    task automatic test_stream();
        int n;
        apply_reset();
        mem_lat = 1;
        bus.en = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(32'(k * 4));
        for (int k = 0; k < 3; k++) begin
            wait_req(12, n);
            if (k == 2) bus.en = 1'b0;
            tests_run += 2;
            if (n !== ((k == 0) ? 1 : 3)) begin
                tests_failed++;
                $display("FAIL stream_spacing_%0d: got %0d cycles want %0d", k, n, (k == 0) ? 1 : 3);
            end
            if (bus.fetch_addr !== 32'(k * 4)) begin
                tests_failed++;
                $display("FAIL stream_addr_%0d: got %h want %h", k, bus.fetch_addr, k * 4);
            end
        end
        wait_valid(10);
        check_queue_empty("stream");
`ifdef FETCH_CTRL_PERF_EN
        tests_run++;
        if (perf_fetch !== 32'd3) begin tests_failed++; $display("FAIL stream_perf_fetch: got %0d want 3", perf_fetch); end
`endif
    endtask

    task automatic test_stall();
        apply_reset();
        mem_lat = 1;
        bus.en = 1'b1;
        bus.stall = 1'b1;
        push_exp(32'd0);
        push_exp(32'd4);
        wait_valid(12);
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run += 3;
            if (bus.inst !== KEY)         begin tests_failed++; $display("FAIL stall_inst: got %h want %h", bus.inst, KEY); end
            if (bus.inst_pc !== 32'd0)    begin tests_failed++; $display("FAIL stall_inst_pc: got %h want 0", bus.inst_pc); end
            if (bus.fetch_req !== 1'b0)   begin tests_failed++; $display("FAIL stall_fetch_req: got %b want 0", bus.fetch_req); end
        end
        bus.stall = 1'b0;
        step();
        bus.en = 1'b0;
        tests_run += 3;
        if (bus.fetch_req !== 1'b1)   begin tests_failed++; $display("FAIL stall_release_req: got %b want 1", bus.fetch_req); end
        if (bus.fetch_addr !== 32'd4) begin tests_failed++; $display("FAIL stall_release_addr: got %h want 4", bus.fetch_addr); end
        if (bus.inst_valid !== 1'b0)  begin tests_failed++; $display("FAIL stall_release_valid: got %b want 0", bus.inst_valid); end
        wait_valid(10);
        check_queue_empty("stall");
    endtask

    task automatic test_redirect_wait();
        int n;
        int kills;
        apply_reset();
        mem_lat = 4;
        bus.en = 1'b1;
        wait_req(12, n);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        push_exp(32'h0000_0100);
        step();
        bus.redirect_valid = 1'b0;
        tests_run += 2;
        if (bus.kill !== 1'b1)  begin tests_failed++; $display("FAIL redir_kill: got %b want 1", bus.kill); end
        if (state !== S_DRAIN)  begin tests_failed++; $display("FAIL redir_drain: got state %0d want %0d", state, S_DRAIN); end
        kills = 1;
        for (int i = 0; i < 12 && !bus.fetch_req; i++) begin
            step();
            if (bus.kill) kills++;
            tests_run++;
            if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_valid_low: got %b want 0", bus.inst_valid); end
        end
        bus.en = 1'b0;
        tests_run += 3;
        if (bus.fetch_req !== 1'b1)           begin tests_failed++; $display("FAIL redir_req: got %b want 1", bus.fetch_req); end
        if (bus.fetch_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL redir_addr: got %h want 00000100", bus.fetch_addr); end
        if (kills !== 1)                      begin tests_failed++; $display("FAIL redir_kill_count: got %0d want 1", kills); end
        wait_valid(12);
        check_queue_empty("redir");
`ifdef FETCH_CTRL_PERF_EN
        tests_run++;
        if (perf_squash !== 32'd1) begin tests_failed++; $display("FAIL redir_perf_squash: got %0d want 1", perf_squash); end
`endif
    endtask

    task automatic test_redirect_same_cycle();
        int n;
        apply_reset();
        mem_lat = 2;
        bus.en = 1'b1;
        wait_req(12, n);
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.fetch_data_valid) break;
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0400;
        push_exp(32'h0000_0400);
        step();
        bus.redirect_valid = 1'b0;
        bus.en = 1'b0;
        tests_run += 4;
        if (bus.kill !== 1'b1)                begin tests_failed++; $display("FAIL same_kill: got %b want 1", bus.kill); end
        if (bus.inst_valid !== 1'b0)          begin tests_failed++; $display("FAIL same_valid: got %b want 0", bus.inst_valid); end
        if (bus.fetch_req !== 1'b1)           begin tests_failed++; $display("FAIL same_req: got %b want 1", bus.fetch_req); end
        if (bus.fetch_addr !== 32'h0000_0400) begin tests_failed++; $display("FAIL same_addr: got %h want 00000400", bus.fetch_addr); end
        wait_valid(10);
        tests_run++;
        if (bus.inst !== (32'h0000_0400 ^ KEY)) begin
            tests_failed++;
            $display("FAIL same_inst: got %h want %h", bus.inst, 32'h0000_0400 ^ KEY);
        end
        check_queue_empty("same");
`ifdef FETCH_CTRL_PERF_EN
        tests_run++;
        if (perf_squash !== 32'd1) begin tests_failed++; $display("FAIL same_perf_squash: got %0d want 1", perf_squash); end
`endif
    endtask

    task automatic test_double_drain();
        int n;
        apply_reset();
        mem_lat = 6;
        bus.en = 1'b1;
        wait_req(12, n);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        step();
        bus.redirect_pc = 32'h0000_0300;
        step();
        bus.redirect_valid = 1'b0;
        push_exp(32'h0000_0300);
        tests_run++;
        if (state !== S_DRAIN) begin tests_failed++; $display("FAIL drain_state: got %0d want %0d", state, S_DRAIN); end
        wait_req(12, n);
        bus.en = 1'b0;
        tests_run++;
        if (bus.fetch_addr !== 32'h0000_0300) begin tests_failed++; $display("FAIL drain_addr: got %h want 00000300", bus.fetch_addr); end
        wait_valid(12);
        check_queue_empty("drain");
    endtask

    task automatic test_en_low_mid();
        int n;
        apply_reset();
        mem_lat = 3;
        bus.en = 1'b1;
        wait_req(12, n);
        bus.en = 1'b0;
        push_exp(32'd0);
        wait_valid(10);
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (bus.fetch_req !== 1'b0) begin tests_failed++; $display("FAIL enlow_req: got %b want 0", bus.fetch_req); end
        end
        tests_run++;
        if (state !== S_IDLE) begin tests_failed++; $display("FAIL enlow_state: got %0d want %0d", state, S_IDLE); end
        check_queue_empty("enlow");
    endtask

    task automatic test_rst_in_wait();
        int n;
        mem_lat = 5;
        bus.en = 1'b1;
        wait_req(12, n);
        step();
        rst = 1'b1;
        bus.en = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run += 7;
            if (state !== S_IDLE)         begin tests_failed++; $display("FAIL rstw_state: got %0d want %0d", state, S_IDLE); end
            if (bus.fetch_req !== 1'b0)   begin tests_failed++; $display("FAIL rstw_req: got %b want 0", bus.fetch_req); end
            if (bus.fetch_addr !== 32'd0) begin tests_failed++; $display("FAIL rstw_addr: got %h want 0", bus.fetch_addr); end
            if (bus.inst_valid !== 1'b0)  begin tests_failed++; $display("FAIL rstw_valid: got %b want 0", bus.inst_valid); end
            if (bus.inst !== NOP)         begin tests_failed++; $display("FAIL rstw_inst: got %h want %h", bus.inst, NOP); end
            if (bus.inst_pc !== 32'd0)    begin tests_failed++; $display("FAIL rstw_inst_pc: got %h want 0", bus.inst_pc); end
            if (bus.kill !== 1'b0)        begin tests_failed++; $display("FAIL rstw_kill: got %b want 0", bus.kill); end
        end
`ifdef FETCH_CTRL_PERF_EN
        tests_run++;
        if (perf_fetch !== 32'd0 || perf_squash !== 32'd0) begin
            tests_failed++;
            $display("FAIL rstw_perf: got %0d/%0d want 0/0", perf_fetch, perf_squash);
        end
`endif
    endtask

    initial begin
        bus.en = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.fetch_data_valid = 1'b0;
        bus.request_data = 32'd0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_double_drain();
        test_en_low_mid();
        test_rst_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
